// File: rtl/mod_arith_pkg.sv
// Shared types and helpers for the modular-arithmetic family.
// Digit-serial units derive their digit count and width legality here.
package mod_arith_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SUB,
      ADD,
      DONE
   } state_t;

   function automatic int calc_k(
      input int width,
      input int digit
   );
      return width / digit;
   endfunction

   function automatic bit width_ok(
      input int width,
      input int digit
   );
      return (digit > 0) && (width >= digit) && (width % digit == 0);
   endfunction

endpackage

// File: rtl/mod_digit_addsub.sv
// One-digit adder/subtractor shared by both phases of the serial unit.
// In subtract mode cout is the borrow out; in add mode it is the carry.
module mod_digit_addsub #(
   parameter int DIGIT = 16
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   input  logic             sub,
   output logic [DIGIT-1:0] sum,
   output logic             cout
);

   logic [DIGIT:0] res;
   logic [DIGIT:0] cin_w;

   assign cin_w = {{DIGIT{1'b0}}, cin};

   always_comb begin
      if (sub)
         res = {1'b0, x} - {1'b0, y} - cin_w;
      else
         res = {1'b0, x} + {1'b0, y} + cin_w;
   end

   assign sum  = res[DIGIT-1:0];
   assign cout = res[DIGIT];

endmodule

// File: rtl/mod_sub_serial.sv
// Digit-serial S = (A - B) mod N: subtract pass, then an add-back
// pass over N only when the subtract pass ends with a borrow.
module mod_sub_serial
   import mod_arith_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DIGIT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] N,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S
);

   localparam int K  = calc_k(WIDTH, DIGIT);
   localparam int IW = (K > 1) ? $clog2(K) : 1;
   localparam logic [IW-1:0] LAST = IW'(K - 1);

   generate
      if (!width_ok(WIDTH, DIGIT)) begin : g_width_chk
         $error("mod_sub_serial: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   state_t state;
   state_t state_n;

   logic [DIGIT-1:0] a_q [K];
   logic [DIGIT-1:0] b_q [K];
   logic [DIGIT-1:0] n_q [K];
   logic [DIGIT-1:0] d_q [K];

   logic [IW-1:0]    idx;
   logic             cy;
   logic             last;
   logic             accept;
   logic             sub;
   logic [DIGIT-1:0] x;
   logic [DIGIT-1:0] y;
   logic [DIGIT-1:0] sum;
   logic             cout;
   logic             in_ready_d;
   logic             out_valid_d;

   assign accept = in_valid && in_ready;
   assign last   = (idx == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (accept) state_n = SUB;
         SUB:  if (last) state_n = cout ? ADD : DONE;
         ADD:  if (last) state_n = DONE;
         DONE: if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Handshake flags are registered from the next state so they
   // switch cleanly on the edge that enters IDLE/DONE.
   always_comb begin
      in_ready_d  = (state_n == IDLE);
      out_valid_d = (state_n == DONE);
      sub         = (state == SUB);
      x           = sub ? a_q[idx] : d_q[idx];
      y           = sub ? b_q[idx] : n_q[idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         in_ready  <= in_ready_d;
         out_valid <= out_valid_d;
      end
   end

   mod_digit_addsub #(
      .DIGIT(DIGIT)
   ) u_digit (
      .x   (x),
      .y   (y),
      .cin (cy),
      .sub (sub),
      .sum (sum),
      .cout(cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < K; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
            n_q[i] <= '0;
            d_q[i] <= '0;
         end
         idx <= '0;
         cy  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  for (int i = 0; i < K; i++) begin
                     a_q[i] <= A[i*DIGIT +: DIGIT];
                     b_q[i] <= B[i*DIGIT +: DIGIT];
                     n_q[i] <= N[i*DIGIT +: DIGIT];
                     d_q[i] <= '0;
                  end
                  idx <= '0;
                  cy  <= 1'b0;
               end
            end
            SUB, ADD: begin
               d_q[idx] <= sum;
               // Top-digit borrow only steers the FSM; add-back
               // starts with a clear carry and its top carry is dropped.
               if (last) begin
                  idx <= '0;
                  cy  <= 1'b0;
               end else begin
                  idx <= idx + IW'(1);
                  cy  <= cout;
               end
            end
            default: ;
         endcase
      end
   end

   generate
      for (genvar g = 0; g < K; g++) begin : g_s
         assign S[g*DIGIT +: DIGIT] = d_q[g];
      end
   endgenerate

endmodule

// File: tb/tb_mod_sub_serial.sv
// Scoreboard bench for mod_sub_serial: driver queues expectations,
// a negedge monitor pops and compares result and latency.
module tb_mod_sub_serial;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] A;
   logic [63:0] B;
   logic [63:0] N;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] S;

   typedef struct {
      logic [63:0] s;
      int          lat;
      int          acc;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   bit   active;
   int   cyc;
   int   checks;
   int   failures;

   mod_sub_serial #(
      .WIDTH(64),
      .DIGIT(16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .A        (A),
      .B        (B),
      .N        (N),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .S        (S)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         active = 1'b0;
      end else if (out_valid) begin
         if (!active) begin
            active = 1'b1;
            if (q.size() == 0) begin
               checks++;
               failures++;
               cur.s = S;
               $display("FAIL unexpected_out: got S=%h with empty scoreboard", S);
            end else begin
               cur = q.pop_front();
               chk("result", S, cur.s);
               chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
            end
         end else begin
            chk("hold_S", S, cur.s);
         end
      end
   end

   always @(posedge clk)
      if (rst_n && out_valid && out_ready) active = 1'b0;

   task automatic send(input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] n, input logic [63:0] s,
                       input int lat, input bit push);
      int t;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL in_ready_timeout: got 0 want 1");
      end else begin
         in_valid = 1'b1;
         A = a;
         B = b;
         N = n;
         if (push) q.push_back('{s: s, lat: lat, acc: cyc + 1});
         @(negedge clk);
         in_valid = 1'b0;
         A = ~a;
         B = ~b;
         N = ~n;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((q.size() != 0 || active) && t < 300) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (q.size() != 0 || active) begin
         failures++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
   endtask

   initial begin
      #300000;
      failures++;
      $display("FAIL watchdog: got timeout want finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int seen;
      checks    = 0;
      failures  = 0;
      active    = 1'b0;
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      A = '0;
      B = '0;
      N = '0;
      #3 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_S", S, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      send(64'h1, 64'h2, 64'h3, 64'h2, 8, 1'b1);
      send(64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFD,
           64'hFFFFFFFFFFFFFFFF, 64'h1, 4, 1'b1);
      send(64'h023456789ABCDEF0, 64'h0FEDCBA987654321,
           64'h1111111111111111, 64'h03579BE02468ACE0, 8, 1'b1);
      send(64'h7FFFFFFFFFFFFFFE, 64'h7FFFFFFFFFFFFFFE,
           64'hFFFFFFFFFFFFFFFF, 64'h0, 4, 1'b1);
      drain();

      // Back-pressure: hold DONE five cycles, then one-cycle accept.
      out_ready = 1'b0;
      send(64'h5, 64'h3, 64'h7, 64'h2, 4, 1'b1);
      t = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("bp_valid_seen", 64'(out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_release_in_ready", 64'(in_ready), 64'd1);
      chk("bp_release_out_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      send(64'h3, 64'h5, 64'h7, 64'h5, 8, 1'b1);
      drain();

      // Abort mid-operation: nothing queued, nothing may appear.
      send(64'h1, 64'h2, 64'h3, 64'h2, 8, 1'b0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_S", S, 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("abort_no_stale", 64'(seen), 64'd0);

      send(64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFD,
           64'hFFFFFFFFFFFFFFFF, 64'h1, 4, 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
